// File: rtl/unsigned_mult_arbiter.sv
// Round-robin share of one pipelined unsigned multiplier; result LATENCY-1 cycles after the accept edge.
// A stalled result port freezes every stage and withholds all grants until the result is taken.
module unsigned_mult_arbiter #(
  parameter  int NREQ    = 4,
  parameter  int AWIDTH  = 16,
  parameter  int BWIDTH  = 16,
  parameter  int LATENCY = 3,
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NREQ-1:0]            i_req_valid,
  output logic [NREQ-1:0]            o_req_ready,
  input  logic [NREQ*AWIDTH-1:0]     i_a,
  input  logic [NREQ*BWIDTH-1:0]     i_b,
  output logic                       o_res_valid,
  input  logic                       i_res_ready,
  output logic [IDW-1:0]             o_res_id,
  output logic [AWIDTH+BWIDTH:0]     o_res_prod,
  output logic                       o_busy
);

  localparam int PW = AWIDTH + BWIDTH + 1;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
    logic [PW-1:0]  prod;
  } stage_t;

  stage_t            stage_q [LATENCY];
  stage_t            stage_d [LATENCY];
  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    ptr_d;
  logic [IDW-1:0]    gnt_id;
  logic              gnt_found;
  logic              en;
  logic              accept;
  int                scan;
  logic [AWIDTH-1:0] a_sel;
  logic [BWIDTH-1:0] b_sel;
  logic [PW-1:0]     prod_d;

  assign en     = ~stage_q[LATENCY-1].vld | i_res_ready;
  assign accept = en & gnt_found;

  // First valid requester at or above the pointer, wrapping past NREQ-1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan      = 0;
    for (int i = 0; i < NREQ; i++) begin
      scan = int'(ptr_q) + i;
      if (scan >= NREQ) scan = scan - NREQ;
      if (!gnt_found && i_req_valid[IDW'(scan)]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(scan);
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (accept) o_req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
  end

  assign a_sel  = AWIDTH'(i_a >> (int'(gnt_id) * AWIDTH));
  assign b_sel  = BWIDTH'(i_b >> (int'(gnt_id) * BWIDTH));
  assign prod_d = {1'b0, ({{BWIDTH{1'b0}}, a_sel} * {{AWIDTH{1'b0}}, b_sel})};

  // Bubbles advance like real entries; only the data of an accepted pair is loaded.
  always_comb begin
    for (int s = 0; s < LATENCY; s++) stage_d[s] = stage_q[s];
    if (en) begin
      stage_d[0].vld = accept;
      if (accept) begin
        stage_d[0].id   = gnt_id;
        stage_d[0].prod = prod_d;
      end
      for (int s = 1; s < LATENCY; s++) stage_d[s] = stage_q[s-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q   <= '0;
      stage_q <= '{default: '0};
    end else begin
      ptr_q   <= ptr_d;
      stage_q <= stage_d;
    end
  end

  always_comb begin
    o_busy = 1'b0;
    for (int s = 0; s < LATENCY; s++) o_busy = o_busy | stage_q[s].vld;
  end

  assign o_res_valid = stage_q[LATENCY-1].vld;
  assign o_res_id    = stage_q[LATENCY-1].id;
  assign o_res_prod  = stage_q[LATENCY-1].prod;

endmodule

// File: tb/tb_unsigned_mult_arbiter.sv
// Scoreboard bench for unsigned_mult_arbiter: directed scenarios plus a randomised soak with ready toggling.
module tb_unsigned_mult_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 16;
  localparam int BW   = 16;
  localparam int LAT  = 3;
  localparam int IDW  = 2;
  localparam int PW   = AW + BW + 1;

  typedef logic [IDW+PW-1:0] ent_t;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n = 1'b0;
  logic [NREQ-1:0]      i_req_valid;
  logic [NREQ-1:0]      o_req_ready;
  logic [NREQ*AW-1:0]   i_a;
  logic [NREQ*BW-1:0]   i_b;
  logic                 o_res_valid;
  logic                 i_res_ready;
  logic [IDW-1:0]       o_res_id;
  logic [PW-1:0]        o_res_prod;
  logic                 o_busy;

  logic [AW-1:0] a_l [NREQ];
  logic [BW-1:0] b_l [NREQ];

  assign i_a = {a_l[3], a_l[2], a_l[1], a_l[0]};
  assign i_b = {b_l[3], b_l[2], b_l[1], b_l[0]};

  unsigned_mult_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .BWIDTH(BW), .LATENCY(LAT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_a(i_a), .i_b(i_b), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res_id(o_res_id), .o_res_prod(o_res_prod), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_push = 0;
  int   n_pop = 0;
  ent_t exp_q [$];
  ent_t res_hist [$];
  int   gnt_hist [$];

  int              mptr = 0;
  int              m_g;
  logic            m_en;
  logic [NREQ-1:0] m_rdy;
  ent_t            m_ent;
  logic            hold_v = 1'b0;
  logic [IDW-1:0]  hold_id;
  logic [PW-1:0]   hold_prod;

  // Monitor: output hold, in-order result scoreboard, and round-robin grant model.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      exp_q.delete();
      mptr   = 0;
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        n_vec++;
        if (!o_res_valid || o_res_id !== hold_id || o_res_prod !== hold_prod) begin
          n_err++;
          $display("FAIL hold: got vld=%0b id=%0d prod=%h, expected vld=1 id=%0d prod=%h",
                   o_res_valid, o_res_id, o_res_prod, hold_id, hold_prod);
        end
      end
      if (o_res_valid && i_res_ready) begin
        n_vec++;
        n_pop++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL result: got id=%0d prod=%h, expected no result outstanding", o_res_id, o_res_prod);
        end else begin
          m_ent = exp_q.pop_front();
          if ({o_res_id, o_res_prod} !== m_ent) begin
            n_err++;
            $display("FAIL result: got id=%0d prod=%h, expected id=%0d prod=%h",
                     o_res_id, o_res_prod, m_ent[IDW+PW-1:PW], m_ent[PW-1:0]);
          end
        end
        res_hist.push_back({o_res_id, o_res_prod});
      end
      hold_v    = o_res_valid && !i_res_ready;
      hold_id   = o_res_id;
      hold_prod = o_res_prod;

      m_en = !o_res_valid || i_res_ready;
      m_g  = -1;
      for (int i = 0; i < NREQ; i++)
        if (m_g < 0 && ((i_req_valid >> ((mptr + i) % NREQ)) & 4'b0001) != 4'b0000)
          m_g = (mptr + i) % NREQ;
      m_rdy = (m_en && m_g >= 0) ? (4'b0001 << m_g) : 4'b0000;
      n_vec++;
      if (o_req_ready !== m_rdy) begin
        n_err++;
        $display("FAIL grant: got ready=%b, expected ready=%b (valid=%b)", o_req_ready, m_rdy, i_req_valid);
      end
      if (m_en && m_g >= 0) begin
        exp_q.push_back({IDW'(m_g), 33'(a_l[m_g]) * 33'(b_l[m_g])});
        n_push++;
        gnt_hist.push_back(m_g);
        mptr = (m_g + 1) % NREQ;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic int gh(input int i);
    return (i < gnt_hist.size()) ? gnt_hist[i] : -1;
  endfunction

  function automatic ent_t rh(input int i);
    return (i < res_hist.size()) ? res_hist[i] : '1;
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Hold every pending request until it is accepted.
  task automatic serve(input int maxc);
    int c;
    logic [NREQ-1:0] acc;
    c = 0;
    while (i_req_valid != '0 && c < maxc) begin
      @(negedge i_clk);
      acc = o_req_ready & i_req_valid;
      @(posedge i_clk);
      #1;
      i_req_valid = i_req_valid & ~acc;
      c++;
    end
    chk("serve_pending", 64'(i_req_valid), 64'h0);
    i_req_valid = '0;
  endtask

  task automatic drain();
    int c;
    i_req_valid = '0;
    i_res_ready = 1'b1;
    c = 0;
    while ((exp_q.size() != 0 || o_busy) && c < 50) begin
      tick();
      c++;
    end
    chk("drain_queue", 64'(exp_q.size()), 64'h0);
    chk("drain_busy", 64'(o_busy), 64'h0);
  endtask

  int fair_g [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  logic [PW-1:0] fair_p [4] = '{33'h1, 33'h20, 33'h300, 33'h4000};

  initial begin
    int lat;
    int c;
    int n_acc;
    logic [NREQ-1:0] acc;

    i_req_valid = '0;
    i_res_ready = 1'b1;
    for (int r = 0; r < NREQ; r++) begin
      a_l[r] = '0;
      b_l[r] = '0;
    end

    #12;
    chk("rst_valid", 64'(o_res_valid), 64'h0);
    chk("rst_busy", 64'(o_busy), 64'h0);
    chk("rst_id", 64'(o_res_id), 64'h0);
    chk("rst_prod", 64'(o_res_prod), 64'h0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    tick();

    // Fairness: all four hold valid, grants rotate from pointer 0.
    a_l[0] = 16'h0001; b_l[0] = 16'h0001;
    a_l[1] = 16'h0002; b_l[1] = 16'h0010;
    a_l[2] = 16'h0003; b_l[2] = 16'h0100;
    a_l[3] = 16'h0004; b_l[3] = 16'h1000;
    gnt_hist.delete();
    res_hist.delete();
    i_req_valid = 4'hF;
    repeat (8) tick();
    i_req_valid = '0;
    drain();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fair_gnt%0d", i), 64'(gh(i)), 64'(fair_g[i]));
      chk($sformatf("fair_id%0d", i), 64'(rh(i) >> PW), 64'(fair_g[i]));
      chk($sformatf("fair_prod%0d", i), 64'(rh(i) & {PW{1'b1}}), 64'(fair_p[fair_g[i]]));
    end

    // Single op: full-scale product with latency measured from the accept edge.
    a_l[2] = 16'hFFFF; b_l[2] = 16'hFFFF;
    i_req_valid = 4'b0100;
    serve(20);
    lat = 0;
    do begin
      @(negedge i_clk);
      lat++;
    end while (!o_res_valid && lat < 10);
    chk("single_lat", 64'(lat), 64'(LAT));
    chk("single_id", 64'(o_res_id), 64'h2);
    chk("single_prod", 64'(o_res_prod), 64'h0_FFFE_0001);
    drain();

    // Backpressure: stall the result port for 5 cycles with requests pending.
    a_l[2] = 16'h0003; b_l[2] = 16'h0100;
    i_req_valid = 4'hF;
    repeat (4) tick();
    i_res_ready = 1'b0;
    repeat (5) tick();
    @(negedge i_clk);
    chk("bp_ready", 64'(o_req_ready), 64'h0);
    chk("bp_valid", 64'(o_res_valid), 64'h1);
    @(posedge i_clk);
    #1;
    i_res_ready = 1'b1;
    repeat (6) tick();
    drain();
    chk("bp_count", 64'(n_pop), 64'(n_push));

    // Sparse: requester 1 alone, then 0 and 3 together -> pointer at 2 picks 3, then wraps to 0.
    gnt_hist.delete();
    a_l[1] = 16'h0007; b_l[1] = 16'h0009;
    i_req_valid = 4'b0010;
    serve(20);
    i_req_valid = 4'b1001;
    serve(20);
    drain();
    chk("sparse_g0", 64'(gh(0)), 64'h1);
    chk("sparse_g1", 64'(gh(1)), 64'h3);
    chk("sparse_g2", 64'(gh(2)), 64'h0);

    // Operand corners.
    res_hist.delete();
    a_l[3] = 16'h0000; b_l[3] = 16'hFFFF;
    i_req_valid = 4'b1000;
    serve(20);
    a_l[3] = 16'h0001; b_l[3] = 16'h1234;
    i_req_valid = 4'b1000;
    serve(20);
    drain();
    chk("op_zero", 64'(rh(0)), 64'({2'd3, 33'h0}));
    chk("op_one", 64'(rh(1)), 64'({2'd3, 33'h1234}));

    // Random soak: 1000 pairs, random valids, operands and ready.
    n_acc = 0;
    c = 0;
    while (n_acc < 1000 && c < 20000) begin
      @(negedge i_clk);
      acc = o_req_ready & i_req_valid;
      n_acc += $countones(acc);
      @(posedge i_clk);
      #1;
      i_res_ready = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < NREQ; r++) begin
        if (((acc | ~i_req_valid) >> r) & 4'b0001) begin
          i_req_valid = ($urandom_range(0, 1) != 0) ? (i_req_valid | (4'b0001 << r))
                                                     : (i_req_valid & ~(4'b0001 << r));
          a_l[r] = rnd16();
          b_l[r] = rnd16();
        end
      end
      c++;
    end
    chk("rand_accepts", 64'(n_acc >= 1000), 64'h1);
    drain();
    chk("rand_count", 64'(n_pop), 64'(n_push));

    // Reset with three entries in flight.
    i_res_ready = 1'b0;
    a_l[0] = 16'h0011; b_l[0] = 16'h0022;
    i_req_valid = 4'hF;
    repeat (3) tick();
    i_req_valid = '0;
    chk("pre_rst_busy", 64'(o_busy), 64'h1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(o_res_valid), 64'h0);
    chk("mid_rst_busy", 64'(o_busy), 64'h0);
    @(negedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_res_ready = 1'b1;
    repeat (5) tick();
    chk("post_rst_busy", 64'(o_busy), 64'h0);
    chk("post_rst_valid", 64'(o_res_valid), 64'h0);
    gnt_hist.delete();
    i_req_valid = 4'hF;
    tick();
    i_req_valid = '0;
    chk("post_rst_gnt", 64'(gh(0)), 64'h0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000 ns, expected summary earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
